// File: rtl/div_share_arbiter.sv
// Shares one external iterative divider among NUM_REQ requesters using a
// round-robin grant; divide-by-zero requests are answered locally.
module div_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WidthD0 = 20,
    parameter int WidthD1 = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WidthD0-1:0] req_a,
    input  logic [NUM_REQ*WidthD1-1:0] req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         resp_valid,
    output logic [WidthD0-1:0]         resp_result,
    output logic                       resp_div0,
    output logic                       div_load,
    output logic [WidthD0-1:0]         div_a,
    output logic [WidthD1-1:0]         div_b,
    input  logic                       div_valid,
    input  logic [WidthD0-1:0]         div_result,
    output logic                       busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   owner_q, owner_d;
    logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
    logic [WidthD0-1:0]   result_q, result_d;
    logic                 div0_q, div0_d;
    logic                 div_load_q, div_load_d;
    logic [WidthD0-1:0]   div_a_q, div_a_d;
    logic [WidthD1-1:0]   div_b_q, div_b_d;
    logic                 busy_q, busy_d;

    logic                 found_s;
    logic [PW-1:0]        grant_s;
    logic [PW:0]          sum_s;
    logic [PW-1:0]        idx_s;
    logic [NUM_REQ-1:0]   grant_oh_s;
    logic [WidthD0-1:0]   sel_a_s;
    logic [WidthD1-1:0]   sel_b_s;
    logic [NUM_REQ-1:0]   req_ready_s;

    // Round-robin search: first requester at or after ptr with req_valid set.
    always_comb begin
        found_s = 1'b0;
        grant_s = '0;
        sum_s   = '0;
        idx_s   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum_s = {1'b0, ptr_q} + (PW+1)'(k);
            if (sum_s >= (PW+1)'(NUM_REQ)) begin
                sum_s = sum_s - (PW+1)'(NUM_REQ);
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[PW-1:0];
            if (!found_s && req_valid[idx_s]) begin
                found_s = 1'b1;
                grant_s = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Operand mux and one-hot decode for the selected requester.
    always_comb begin
        grant_oh_s = '0;
        sel_a_s    = '0;
        sel_b_s    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s == PW'(i)) begin
                grant_oh_s[i] = 1'b1;
                sel_a_s       = req_a[i*WidthD0 +: WidthD0];
                sel_b_s       = req_b[i*WidthD1 +: WidthD1];
            end else begin
                grant_oh_s[i] = 1'b0;
            end
        end
    end

    // Next-state and next-output logic; outputs are registered from the next state.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        result_d    = result_q;
        div0_d      = div0_q;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        req_ready_s = '0;
        case (state_q)
            IDLE: begin
                if (found_s && !rst) begin
                    req_ready_s = grant_oh_s;
                    owner_d     = grant_oh_s;
                    ptr_d       = (grant_s == PW'(NUM_REQ-1)) ? '0 : grant_s + PW'(1);
                    div_a_d     = sel_a_s;
                    div_b_d     = sel_b_s;
                    if (sel_b_s == '0) begin
                        // Zero divisor never reaches the divider.
                        state_d  = RESP;
                        result_d = '1;
                        div0_d   = 1'b1;
                    end else begin
                        state_d  = LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (div_valid) begin
                    result_d = div_result;
                    div0_d   = 1'b0;
                    state_d  = RESP;
                end else begin
                    state_d  = WAIT;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        resp_valid_d = (state_d == RESP) ? owner_d : '0;
        div_load_d   = (state_d == LOAD);
        busy_d       = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            resp_valid_q <= '0;
            result_q     <= '0;
            div0_q       <= 1'b0;
            div_load_q   <= 1'b0;
            div_a_q      <= '0;
            div_b_q      <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            resp_valid_q <= resp_valid_d;
            result_q     <= result_d;
            div0_q       <= div0_d;
            div_load_q   <= div_load_d;
            div_a_q      <= div_a_d;
            div_b_q      <= div_b_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready   = req_ready_s;
    assign resp_valid  = resp_valid_q;
    assign resp_result = result_q;
    assign resp_div0   = div0_q;
    assign div_load    = div_load_q;
    assign div_a       = div_a_q;
    assign div_b       = div_b_q;
    assign busy        = busy_q;

endmodule
